// File: rtl/hello_pkg.sv
// rtl/hello_pkg.sv - shared types and constants for the hello sequencer
// Contents: state_t FSM encoding, MSG_LEN, CR/LF characters, PASS_LEN.
// Build option: HELLO_SEQ_CRLF_EN appends CR LF to every pass (22 chars).
package hello_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam int         MSG_LEN = 20;
   localparam logic [7:0] CHAR_CR = 8'h0D;
   localparam logic [7:0] CHAR_LF = 8'h0A;

`ifdef HELLO_SEQ_CRLF_EN
   localparam int PASS_LEN = MSG_LEN + 2;
`else
   localparam int PASS_LEN = MSG_LEN;
`endif

endpackage

// File: rtl/hello_msg_rom.sv
// rtl/hello_msg_rom.sv - combinational ROM holding "Hello World by Angad"
// Ports: i_index [4:0] character index, o_char [7:0] ASCII character
//        (8'h00 for indexes beyond the message).
module hello_msg_rom (
   input  logic [4:0] i_index,
   output logic [7:0] o_char
);

   always_comb begin
      o_char = 8'h00;
      case (i_index)
         5'd0:  o_char = 8'h48; // H
         5'd1:  o_char = 8'h65; // e
         5'd2:  o_char = 8'h6C; // l
         5'd3:  o_char = 8'h6C; // l
         5'd4:  o_char = 8'h6F; // o
         5'd5:  o_char = 8'h20;
         5'd6:  o_char = 8'h57; // W
         5'd7:  o_char = 8'h6F; // o
         5'd8:  o_char = 8'h72; // r
         5'd9:  o_char = 8'h6C; // l
         5'd10: o_char = 8'h64; // d
         5'd11: o_char = 8'h20;
         5'd12: o_char = 8'h62; // b
         5'd13: o_char = 8'h79; // y
         5'd14: o_char = 8'h20;
         5'd15: o_char = 8'h41; // A
         5'd16: o_char = 8'h6E; // n
         5'd17: o_char = 8'h67; // g
         5'd18: o_char = 8'h61; // a
         5'd19: o_char = 8'h64; // d
         default: o_char = 8'h00;
      endcase
   end

endmodule

// File: rtl/hello_sequencer.sv
// rtl/hello_sequencer.sv - streams the hello message over a valid/ready handshake
// Parameters: GAP_CYCLES (0..255) idle cycles after each accepted character,
//             REPEATS (1..255) message passes per start.
// Ports: i_clock, i_reset (sync, active-high), i_start (one-cycle request),
//        i_ready (sink accepts), o_busy (not idle), o_valid/o_data [7:0]
//        (character presented), o_done (one-cycle end pulse),
//        o_count [7:0] (characters accepted in the current sequence).
// Build option: HELLO_SEQ_CRLF_EN appends CR LF to every pass.
module hello_sequencer
   import hello_pkg::*;
#(
   parameter int GAP_CYCLES = 0,
   parameter int REPEATS    = 1
) (
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       i_start,
   output logic       o_busy,
   output logic       o_valid,
   input  logic       i_ready,
   output logic [7:0] o_data,
   output logic       o_done,
   output logic [7:0] o_count
);

   localparam logic [4:0] LAST_IDX  = 5'(PASS_LEN - 1);
   localparam logic [7:0] LAST_PASS = 8'(REPEATS - 1);
   localparam logic [7:0] GAP_LOAD  = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   state_t     r_state;
   logic [4:0] r_index;
   logic [7:0] r_pass;
   logic [7:0] r_gap;
   logic [7:0] r_count;
   logic       r_busy;
   logic       r_valid;
   logic [7:0] r_data;
   logic       r_done;

   logic [4:0] w_next_idx;
   logic [4:0] w_rom_addr;
   logic [7:0] w_rom_char;
   logic [7:0] w_char;
   logic       w_last_char;
   logic       w_last_pass;
   logic       w_fire;

   assign w_last_char = (r_index == LAST_IDX);
   assign w_last_pass = (r_pass == LAST_PASS);
   assign w_next_idx  = w_last_char ? 5'd0 : r_index + 5'd1;
   assign w_fire      = r_valid & i_ready;

   // o_data is registered, so the ROM is addressed with the character that
   // will be presented next: index 0 on start, the following index on a
   // back-to-back transfer, the already-advanced index when leaving GAP.
   always_comb begin
      w_rom_addr = r_index;
      case (r_state)
         ST_IDLE: w_rom_addr = 5'd0;
         ST_SEND: w_rom_addr = w_next_idx;
         default: w_rom_addr = r_index;
      endcase
   end

   hello_msg_rom u_rom (
      .i_index (w_rom_addr),
      .o_char  (w_rom_char)
   );

`ifdef HELLO_SEQ_CRLF_EN
   always_comb begin
      w_char = w_rom_char;
      if (w_rom_addr == 5'(MSG_LEN))
         w_char = CHAR_CR;
      else if (w_rom_addr == 5'(MSG_LEN + 1))
         w_char = CHAR_LF;
   end
`else
   assign w_char = w_rom_char;
`endif

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_index <= 5'd0;
         r_pass  <= 8'd0;
         r_gap   <= 8'd0;
         r_count <= 8'd0;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
         r_data  <= 8'd0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_state <= ST_SEND;
                  r_index <= 5'd0;
                  r_pass  <= 8'd0;
                  r_count <= 8'd0;
                  r_busy  <= 1'b1;
                  r_valid <= 1'b1;
                  r_data  <= w_char;
               end
            end
            ST_SEND: begin
               if (w_fire) begin
                  r_count <= r_count + 8'd1;
                  r_index <= w_next_idx;
                  if (w_last_char)
                     r_pass <= r_pass + 8'd1;
                  // The final character of the final pass skips the gap.
                  if (w_last_char && w_last_pass) begin
                     r_state <= ST_DONE;
                     r_valid <= 1'b0;
                     r_data  <= 8'd0;
                     r_done  <= 1'b1;
                  end else if (GAP_CYCLES != 0) begin
                     r_state <= ST_GAP;
                     r_gap   <= GAP_LOAD;
                     r_valid <= 1'b0;
                     r_data  <= 8'd0;
                  end else begin
                     r_data  <= w_char;
                  end
               end
            end
            ST_GAP: begin
               if (r_gap == 8'd0) begin
                  r_state <= ST_SEND;
                  r_valid <= 1'b1;
                  r_data  <= w_char;
               end else begin
                  r_gap <= r_gap - 8'd1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_busy  = r_busy;
   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_done  = r_done;
   assign o_count = r_count;

endmodule

// File: tb/tb_hello_sequencer.sv
// tb/tb_hello_sequencer.sv - self-checking bench for hello_sequencer
// Two instances (GAP 0 / REPEATS 1 and GAP 3 / REPEATS 2) share stimulus and
// are compared every cycle against a per-instance behavioural model.
// Build option: HELLO_SEQ_CRLF_EN selects 22-character passes.
module tb_hello_sequencer;

   localparam int GAP_A = 0;
   localparam int REP_A = 1;
   localparam int GAP_B = 3;
   localparam int REP_B = 2;
`ifdef HELLO_SEQ_CRLF_EN
   localparam int PLEN  = 22;
   localparam int LAT_B = 173;
`else
   localparam int PLEN  = 20;
   localparam int LAT_B = 157;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       start;
   logic       ready;
   logic       busy  [2];
   logic       valid [2];
   logic       done  [2];
   logic [7:0] data  [2];
   logic [7:0] count [2];

   hello_sequencer #(.GAP_CYCLES(GAP_A), .REPEATS(REP_A)) u_dut_a (
      .i_clock(clk), .i_reset(rst), .i_start(start), .o_busy(busy[0]),
      .o_valid(valid[0]), .i_ready(ready), .o_data(data[0]),
      .o_done(done[0]), .o_count(count[0])
   );

   hello_sequencer #(.GAP_CYCLES(GAP_B), .REPEATS(REP_B)) u_dut_b (
      .i_clock(clk), .i_reset(rst), .i_start(start), .o_busy(busy[1]),
      .o_valid(valid[1]), .i_ready(ready), .o_data(data[1]),
      .o_done(done[1]), .o_count(count[1])
   );

   logic [7:0] msg [PLEN];
   int gap_k   [2];
   int total_k [2];

   // Model: a sequence is "position within the whole stream" plus a wait
   // count before the next character may be offered.
   int m_seq   [2] = '{0, 0};
   int m_done  [2] = '{0, 0};
   int m_wait  [2] = '{0, 0};
   int m_pos   [2] = '{0, 0};
   int m_count [2] = '{0, 0};

   int n_tests = 0;
   int n_fail  = 0;
   int chk     = 0;
   int cyc     = 0;

   logic [7:0] rx0 [$];
   logic [7:0] rx1 [$];
   int first_v  [2] = '{-1, -1};
   int done_cyc [2] = '{-1, -1};

   task automatic check(input int k, input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL dut%0d %s: got %0d expected %0d (cycle %0d)", k, name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_seq[k]   <= 0;
            m_done[k]  <= 0;
            m_wait[k]  <= 0;
            m_pos[k]   <= 0;
            m_count[k] <= 0;
         end else if (m_seq[k] == 0) begin
            if (start) begin
               m_seq[k]   <= 1;
               m_pos[k]   <= 0;
               m_wait[k]  <= 0;
               m_count[k] <= 0;
            end
         end else if (m_done[k] != 0) begin
            m_seq[k]  <= 0;
            m_done[k] <= 0;
         end else if (m_wait[k] > 0) begin
            m_wait[k] <= m_wait[k] - 1;
         end else if (ready) begin
            m_count[k] <= (m_count[k] + 1) % 256;
            m_pos[k]   <= m_pos[k] + 1;
            if (m_pos[k] + 1 == total_k[k])
               m_done[k] <= 1;
            else
               m_wait[k] <= gap_k[k];
         end
      end
   end

   always @(negedge clk) begin
      if (chk != 0) begin
         for (int k = 0; k < 2; k++) begin
            int ev;
            int ed;
            ev = (m_seq[k] != 0 && m_done[k] == 0 && m_wait[k] == 0) ? 1 : 0;
            ed = (ev != 0) ? int'(msg[m_pos[k] % PLEN]) : 0;
            check(k, "busy",  int'(busy[k]),  m_seq[k]);
            check(k, "valid", int'(valid[k]), ev);
            check(k, "data",  int'(data[k]),  ed);
            check(k, "done",  int'(done[k]),  m_done[k]);
            check(k, "count", int'(count[k]), m_count[k]);
         end
         if (!rst) begin
            if (valid[0] && ready) rx0.push_back(data[0]);
            if (valid[1] && ready) rx1.push_back(data[1]);
            for (int k = 0; k < 2; k++) begin
               if (valid[k] && first_v[k] < 0) first_v[k] = cyc;
               if (done[k] && done_cyc[k] < 0) done_cyc[k] = cyc;
            end
         end
      end
   end

   task automatic wait_idle(input int limit);
      int i;
      i = 0;
      while ((busy[0] || busy[1]) && i < limit) begin
         @(negedge clk);
         i++;
      end
      check(0, "idle_timeout", int'(busy[0] || busy[1]), 0);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_count_a(input int target, input string name);
      int i;
      i = 0;
      while (int'(count[0]) != target && i < 100) begin
         @(negedge clk);
         i++;
      end
      check(0, name, int'(count[0]), target);
   endtask

   initial begin
      string s;
      s = "Hello World by Angad";
      for (int i = 0; i < 20; i++) msg[i] = s[i];
`ifdef HELLO_SEQ_CRLF_EN
      msg[20] = 8'h0D;
      msg[21] = 8'h0A;
`endif
      gap_k[0]   = GAP_A;
      gap_k[1]   = GAP_B;
      total_k[0] = PLEN * REP_A;
      total_k[1] = PLEN * REP_B;

      rst = 1'b1; start = 1'b0; ready = 1'b1;
      repeat (2) @(negedge clk);
      chk = 1;
      for (int k = 0; k < 2; k++) begin
         check(k, "rst_busy",  int'(busy[k]),  0);
         check(k, "rst_valid", int'(valid[k]), 0);
         check(k, "rst_data",  int'(data[k]),  0);
         check(k, "rst_done",  int'(done[k]),  0);
         check(k, "rst_count", int'(count[k]), 0);
      end
      rst = 1'b0;
      @(negedge clk);

      // Full run with ready held high on both instances.
      rx0.delete(); rx1.delete();
      first_v = '{-1, -1}; done_cyc = '{-1, -1};
      pulse_start();
      for (int i = 0; i < 600 && !(done_cyc[0] >= 0 && done_cyc[1] >= 0); i++) @(negedge clk);
      check(0, "run_timeout", int'(done_cyc[0] >= 0 && done_cyc[1] >= 0), 1);
      wait_idle(50);
      check(0, "n_chars",     rx0.size(), PLEN);
      check(0, "first_H",     int'(rx0[0]), 8'h48);
      check(0, "idx4_o",      int'(rx0[4]), 8'h6F);
      check(0, "idx19_d",     int'(rx0[19]), 8'h64);
      check(0, "latency",     done_cyc[0] - first_v[0], PLEN);
      check(0, "count_hold",  int'(count[0]), PLEN);
      check(1, "n_chars",     rx1.size(), 2 * PLEN);
      check(1, "pass2_H",     int'(rx1[PLEN]), 8'h48);
`ifdef HELLO_SEQ_CRLF_EN
      check(1, "cr_after_d",  int'(rx1[20]), 8'h0D);
      check(1, "lf_after_cr", int'(rx1[21]), 8'h0A);
`else
      check(1, "H_after_d",   int'(rx1[20]), 8'h48);
`endif
      check(1, "latency",     done_cyc[1] - first_v[1], LAT_B);
      check(1, "count_hold",  int'(count[1]), 2 * PLEN);

      // Backpressure while index 4 is presented.
      pulse_start();
      wait_count_a(4, "reach_idx4");
      ready = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check(0, "stall_data",  int'(data[0]),  8'h6F);
         check(0, "stall_valid", int'(valid[0]), 1);
         check(0, "stall_count", int'(count[0]), 4);
      end
      ready = 1'b1;
      wait_idle(800);

      // Reset in the middle of a sequence, then restart.
      pulse_start();
      wait_count_a(10, "reach_idx10");
      rst = 1'b1;
      @(negedge clk);
      check(0, "abort_busy",  int'(busy[0]),  0);
      check(0, "abort_valid", int'(valid[0]), 0);
      check(0, "abort_data",  int'(data[0]),  0);
      check(0, "abort_count", int'(count[0]), 0);
      rst = 1'b0;
      pulse_start();
      check(0, "restart_H", int'(data[0]), 8'h48);
      wait_idle(800);

      // Start mid-sequence is ignored; start right after done is taken.
      pulse_start();
      repeat (5) @(negedge clk);
      pulse_start();
      for (int i = 0; i < 100 && !done[0]; i++) @(negedge clk);
      check(0, "done_seen", int'(done[0]), 1);
      @(negedge clk);
      check(0, "idle_after_done", int'(busy[0]), 0);
      pulse_start();
      check(0, "restart_busy", int'(busy[0]), 1);
      check(0, "restart_data", int'(data[0]), 8'h48);
      wait_idle(800);

      // Random traffic, starts and occasional resets.
      for (int i = 0; i < 4000; i++) begin
         ready = ($urandom_range(0, 99) < 70);
         start = ($urandom_range(0, 99) < 5);
         rst   = ($urandom_range(0, 999) < 3);
         @(negedge clk);
      end
      rst = 1'b0; start = 1'b0; ready = 1'b1;
      wait_idle(800);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
